// File: rtl/pc_flow_controller.sv
`default_nettype none
// ============================================================================
// Module      : pc_flow_controller
// Description : Fetch-PC register with branch/jump redirect, stall hold and
//               post-redirect flush sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_flow_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned BR_FLUSH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_stall,
    input  logic        in_branch_taken,
    input  logic [31:0] in_branch_target,
    input  logic        in_jump,
    input  logic [31:0] in_jump_target,
    output logic [31:0] out_pc,
    output logic        out_branch_sel,
    output logic        out_jump_sel,
    output logic        out_flush,
    output logic [1:0]  out_state
);

    localparam logic [1:0]  C_ST_RUN     = 2'b00;
    localparam logic [1:0]  C_ST_STALL   = 2'b01;
    localparam logic [1:0]  C_ST_FLUSH   = 2'b10;
    localparam logic [1:0]  C_BR_FLUSH   = BR_FLUSH[1:0];
    localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] C_PC_STEP    = 32'd4;

    logic [1:0]  state_q, state_d;
    logic [1:0]  fcnt_q,  fcnt_d;
    logic [31:0] pc_q,    pc_d;
    logic        w_in_flush;
    logic        w_br_acc;
    logic        w_jmp_acc;

    // Redirect requests arriving during FLUSH come from wrong-path instructions.
    // Gating with rst_n keeps the mux selects quiet while reset is held.
    assign w_in_flush = (state_q == C_ST_FLUSH);
    assign w_br_acc   = rst_n & in_branch_taken & ~w_in_flush;
    assign w_jmp_acc  = rst_n & in_jump & ~in_stall & ~w_in_flush & ~w_br_acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_ST_RUN;
            fcnt_q  <= 2'd0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and next-PC logic
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q + C_PC_STEP;

        if (w_br_acc) begin
            pc_d = in_branch_target & C_ALIGN_MASK;
        end else if (w_jmp_acc) begin
            pc_d = in_jump_target & C_ALIGN_MASK;
        end else if (in_stall) begin
            pc_d = pc_q;
        end

        if (w_br_acc) begin
            state_d = C_ST_FLUSH;
            fcnt_d  = C_BR_FLUSH;
        end else if (w_jmp_acc) begin
            state_d = C_ST_FLUSH;
            fcnt_d  = 2'd1;
        end else begin
            case (state_q)
                C_ST_RUN, C_ST_STALL: begin
                    state_d = in_stall ? C_ST_STALL : C_ST_RUN;
                end
                C_ST_FLUSH: begin
                    if (fcnt_q <= 2'd1) begin
                        fcnt_d  = 2'd0;
                        state_d = in_stall ? C_ST_STALL : C_ST_RUN;
                    end else begin
                        fcnt_d  = fcnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = C_ST_RUN;
                    fcnt_d  = 2'd0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        out_pc         = pc_q;
        out_state      = state_q;
        out_flush      = w_in_flush;
        out_branch_sel = w_br_acc;
        out_jump_sel   = w_jmp_acc;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_flow_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_flow_controller
// Description : Directed scoreboard bench for pc_flow_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_flow_controller;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  st;
        logic        fl;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_stall;
    logic        in_branch_taken;
    logic [31:0] in_branch_target;
    logic        in_jump;
    logic [31:0] in_jump_target;
    logic [31:0] out_pc;
    logic        out_branch_sel;
    logic        out_jump_sel;
    logic        out_flush;
    logic [1:0]  out_state;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [1:0] RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10;

    pc_flow_controller #(
        .RESET_PC (32'h0000_0000),
        .BR_FLUSH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_stall         (in_stall),
        .in_branch_taken  (in_branch_taken),
        .in_branch_target (in_branch_target),
        .in_jump          (in_jump),
        .in_jump_target   (in_jump_target),
        .out_pc           (out_pc),
        .out_branch_sel   (out_branch_sel),
        .out_jump_sel     (out_jump_sel),
        .out_flush        (out_flush),
        .out_state        (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic expect_next(input logic [31:0] pc, input logic [1:0] st, input logic fl);
        exp_t e;
        e.pc = pc;
        e.st = st;
        e.fl = fl;
        sb.push_back(e);
    endtask

    // Advance one rising edge and compare the DUT against the oldest expectation.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".pc"},    out_pc,           e.pc);
            chk({tag, ".state"}, 32'(out_state),   32'(e.st));
            chk({tag, ".flush"}, 32'(out_flush),   32'(e.fl));
        end
    endtask

    task automatic sels(input string tag, input logic br, input logic jp);
        #1;
        chk({tag, ".branch_sel"}, 32'(out_branch_sel), 32'(br));
        chk({tag, ".jump_sel"},   32'(out_jump_sel),   32'(jp));
    endtask

    task automatic clear_inputs();
        in_stall         = 1'b0;
        in_branch_taken  = 1'b0;
        in_branch_target = 32'h0;
        in_jump          = 1'b0;
        in_jump_target   = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        chk("reset.pc",    out_pc,           32'h0);
        chk("reset.state", 32'(out_state),   32'(RUN));
        chk("reset.flush", 32'(out_flush),   32'd0);
        sels("reset", 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle sequential fetch
        expect_next(32'h4, RUN, 1'b0);  tick("idle1");
        expect_next(32'h8, RUN, 1'b0);  tick("idle2");
        expect_next(32'hC, RUN, 1'b0);  tick("idle3");
        expect_next(32'h10, RUN, 1'b0); tick("idle4");

        // Taken branch at 0x10: two flush cycles, wrong-path branch ignored
        in_branch_taken = 1'b1; in_branch_target = 32'h200;
        sels("br", 1'b1, 1'b0);
        expect_next(32'h200, FLUSH, 1'b1); tick("br.redirect");
        in_branch_target = 32'h900;
        sels("br.flush_ignore", 1'b0, 1'b0);
        expect_next(32'h204, FLUSH, 1'b1); tick("br.flush2");
        clear_inputs();
        expect_next(32'h208, RUN, 1'b0);   tick("br.done");

        // Simultaneous branch and jump: branch wins
        in_branch_taken = 1'b1; in_branch_target = 32'h300;
        in_jump = 1'b1;         in_jump_target   = 32'h500;
        sels("brjp", 1'b1, 1'b0);
        expect_next(32'h300, FLUSH, 1'b1); tick("brjp.redirect");
        clear_inputs();
        expect_next(32'h304, FLUSH, 1'b1); tick("brjp.flush2");
        expect_next(32'h308, RUN, 1'b0);   tick("brjp.done");

        // Jump to 0x40, then stall there for three cycles
        in_jump = 1'b1; in_jump_target = 32'h40;
        sels("jp40", 1'b0, 1'b1);
        expect_next(32'h40, FLUSH, 1'b1); tick("jp40.redirect");
        clear_inputs();
        in_stall = 1'b1;
        expect_next(32'h40, STALL, 1'b0); tick("stall1");
        in_jump = 1'b1; in_jump_target = 32'h700;
        sels("stall.jump_blocked", 1'b0, 1'b0);
        expect_next(32'h40, STALL, 1'b0); tick("stall2");
        expect_next(32'h40, STALL, 1'b0); tick("stall3");
        clear_inputs();
        expect_next(32'h44, RUN, 1'b0);   tick("stall.release");

        // Wrap-around from the top of the address space
        in_jump = 1'b1; in_jump_target = 32'hFFFF_FFF8;
        expect_next(32'hFFFF_FFF8, FLUSH, 1'b1); tick("wrap.jump");
        clear_inputs();
        expect_next(32'hFFFF_FFFC, RUN, 1'b0);   tick("wrap.top");
        expect_next(32'h0000_0000, RUN, 1'b0);   tick("wrap.zero");

        // Misaligned jump target is aligned on load
        in_jump = 1'b1; in_jump_target = 32'h0000_1003;
        sels("align", 1'b0, 1'b1);
        expect_next(32'h1000, FLUSH, 1'b1); tick("align.load");
        clear_inputs();
        expect_next(32'h1004, RUN, 1'b0);   tick("align.next");

        // Asynchronous reset in the middle of a branch flush
        in_branch_taken = 1'b1; in_branch_target = 32'h2000;
        expect_next(32'h2000, FLUSH, 1'b1); tick("rst.branch");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async.pc",    out_pc,         32'h0);
        chk("rst.async.state", 32'(out_state), 32'(RUN));
        chk("rst.async.flush", 32'(out_flush), 32'd0);
        sels("rst.async", 1'b0, 1'b0);
        @(negedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;
        expect_next(32'h4, RUN, 1'b0); tick("rst.after1");
        expect_next(32'h8, RUN, 1'b0); tick("rst.after2");

        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
